alu_op_server: RTL

- Sequential front end that owns the 32-bit ALU command interface; it drives the combinational ALU core rather than testing it.
- Accepts one operation per valid/ready request.
- Drives A, B and the 3-bit command into the ALU and holds them for a fixed settle window, which absorbs the gate-level propagation delay.
- Captures result/carryout/zero/overflow and returns them on a valid/ready response channel.

---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu_ref_model.sv | 50 +++++
 rtl/alu_op_server.sv | 137 +++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command front end: command codes, FSM states, default width.
package alu_pkg;

  localparam int unsigned ALU_WIDTH = 32;
  localparam int unsigned ALU_CMD_W = 3;

  localparam logic [ALU_CMD_W-1:0] ALU_ADD  = 3'd0;
  localparam logic [ALU_CMD_W-1:0] ALU_SUB  = 3'd1;
  localparam logic [ALU_CMD_W-1:0] ALU_XOR  = 3'd2;
  localparam logic [ALU_CMD_W-1:0] ALU_SLT  = 3'd3;
  localparam logic [ALU_CMD_W-1:0] ALU_AND  = 3'd4;
  localparam logic [ALU_CMD_W-1:0] ALU_NAND = 3'd5;
  localparam logic [ALU_CMD_W-1:0] ALU_NOR  = 3'd6;
  localparam logic [ALU_CMD_W-1:0] ALU_OR   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

endpackage

// File: rtl/alu_ref_model.sv
// Combinational golden model of the 32-bit ALU; only present when ALU_CHECK_EN is defined.
`ifdef ALU_CHECK_EN
module alu_ref_model
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [ALU_CMD_W-1:0] cmd,
  output logic [WIDTH-1:0]     result_c,
  output logic                 carryout_c,
  output logic                 zero_c,
  output logic                 overflow_c
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] dif;

  assign sum = {1'b0, a} + {1'b0, b};
  assign dif = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);

  // Evaluate the selected operation; carry/overflow only meaningful for ADD/SUB
  always_comb begin
    result_c   = '0;
    carryout_c = 1'b0;
    overflow_c = 1'b0;
    case (cmd)
      ALU_ADD: begin
        result_c   = sum[WIDTH-1:0];
        carryout_c = sum[WIDTH];
        overflow_c = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SUB: begin
        result_c   = dif[WIDTH-1:0];
        carryout_c = dif[WIDTH];
        overflow_c = (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_XOR:  result_c = a ^ b;
      ALU_SLT:  result_c = WIDTH'($signed(a) < $signed(b));
      ALU_AND:  result_c = a & b;
      ALU_NAND: result_c = ~(a & b);
      ALU_NOR:  result_c = ~(a | b);
      default:  result_c = a | b;
    endcase
    zero_c = (result_c == '0);
  end

endmodule
`endif

// File: rtl/alu_op_server.sv
// Valid/ready front end for a combinational 32-bit ALU: holds operands for a settle
// window, captures the flags, returns them on a response channel.
// Optional: define ALU_CHECK_EN to add a golden-model cross-check (rsp_mismatch, err_count).
module alu_op_server
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH         = ALU_WIDTH,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [WIDTH-1:0]     req_a,
  input  logic [WIDTH-1:0]     req_b,
  input  logic [ALU_CMD_W-1:0] req_cmd,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [WIDTH-1:0]     rsp_result,
  output logic                 rsp_carryout,
  output logic                 rsp_zero,
  output logic                 rsp_overflow,
  output logic [WIDTH-1:0]     alu_a,
  output logic [WIDTH-1:0]     alu_b,
  output logic [ALU_CMD_W-1:0] alu_cmd,
  input  logic [WIDTH-1:0]     alu_result,
  input  logic                 alu_carryout,
  input  logic                 alu_zero,
  input  logic                 alu_overflow,
  output logic [CNT_W-1:0]     ops_done
`ifdef ALU_CHECK_EN
  ,
  output logic                 rsp_mismatch,
  output logic [CNT_W-1:0]     err_count
`endif
);

  localparam int unsigned SET_W = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);

  // A zero-length settle window would capture before the ALU has seen the operands
  if (SETTLE_CYCLES < 1) begin : g_settle_chk
    $error("alu_op_server: SETTLE_CYCLES must be >= 1");
  end

  state_t           state;
  logic [SET_W-1:0] settle_cnt;

`ifdef ALU_CHECK_EN
  logic [WIDTH-1:0] ref_result_c;
  logic             ref_carryout_c;
  logic             ref_zero_c;
  logic             ref_overflow_c;
  logic             mismatch_c;

  // Golden model watches the same held operands the real ALU sees
  alu_ref_model #(.WIDTH(WIDTH)) u_ref (
    .a          (alu_a),
    .b          (alu_b),
    .cmd        (alu_cmd),
    .result_c   (ref_result_c),
    .carryout_c (ref_carryout_c),
    .zero_c     (ref_zero_c),
    .overflow_c (ref_overflow_c)
  );

  assign mismatch_c = (alu_result   != ref_result_c)   ||
                      (alu_carryout != ref_carryout_c) ||
                      (alu_zero     != ref_zero_c)     ||
                      (alu_overflow != ref_overflow_c);
`endif

  // Request accept -> settle countdown -> capture -> response handshake
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      settle_cnt   <= '0;
      req_ready    <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_result   <= '0;
      rsp_carryout <= 1'b0;
      rsp_zero     <= 1'b0;
      rsp_overflow <= 1'b0;
      alu_a        <= '0;
      alu_b        <= '0;
      alu_cmd      <= '0;
      ops_done     <= '0;
`ifdef ALU_CHECK_EN
      rsp_mismatch <= 1'b0;
      err_count    <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            alu_a      <= req_a;
            alu_b      <= req_b;
            alu_cmd    <= req_cmd;
            settle_cnt <= SET_W'(SETTLE_CYCLES);
            req_ready  <= 1'b0;
            state      <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (settle_cnt == SET_W'(1)) begin
            rsp_result   <= alu_result;
            rsp_carryout <= alu_carryout;
            rsp_zero     <= alu_zero;
            rsp_overflow <= alu_overflow;
`ifdef ALU_CHECK_EN
            rsp_mismatch <= mismatch_c;
`endif
            rsp_valid    <= 1'b1;
            settle_cnt   <= '0;
            state        <= ST_RESP;
          end else begin
            settle_cnt <= settle_cnt - SET_W'(1);
          end
        end
        ST_RESP: begin
          if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
            ops_done  <= ops_done + CNT_W'(1);
`ifdef ALU_CHECK_EN
            if (rsp_mismatch) err_count <= err_count + CNT_W'(1);
`endif
            req_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
